tile_config_mem_ctrl: RTL

TILE_CONFIG_MEM_CTRL -- requirements
Module: tile_config_mem_ctrl

---
 rtl/tile_cfg_pkg.sv | 11 +
 rtl/tile_config_mem_ctrl_if.sv | 31 +++
 rtl/tile_cfg_frame_reg.sv | 20 ++
 rtl/tile_config_mem_ctrl.sv | 87 ++++++++
 4 files changed

// File: rtl/tile_cfg_pkg.sv
// tile_cfg_pkg: shared FSM state type, address-width and frame-mapping helpers
// Contents: state_t (IDLE/READ/COMMIT), aw_f (frame address width), frame_mapped (frame holds config bits)
package tile_cfg_pkg;
    typedef enum logic [1:0] {S_IDLE, S_READ, S_COMMIT} state_t;
    function automatic int aw_f(input int frames);
        return (frames > 1) ? $clog2(frames) : 1;
    endfunction
    function automatic logic frame_mapped(input int frame, input int width, input int nbits);
        return frame * width < nbits;
    endfunction
endpackage

// File: rtl/tile_config_mem_ctrl_if.sv
// tile_config_mem_ctrl_if: frame transfer, commit, error and configuration bus of the tile config controller
// master: drives FrameData/FrameAddr/FrameValid/FrameWrite/Commit/Lock/ErrorClr
// slave:  drives FrameReady/ReadData/ReadValid/CommitDone/Error/ConfigBits/ConfigBits_N
interface tile_config_mem_ctrl_if #(
    parameter int DW = 32,
    parameter int AW = 5,
    parameter int NB = 600
);
    logic [DW-1:0] FrameData;
    logic [AW-1:0] FrameAddr;
    logic          FrameValid;
    logic          FrameWrite;
    logic          FrameReady;
    logic [DW-1:0] ReadData;
    logic          ReadValid;
    logic          Commit;
    logic          CommitDone;
    logic          Lock;
    logic          Error;
    logic          ErrorClr;
    logic [NB-1:0] ConfigBits;
    logic [NB-1:0] ConfigBits_N;
    modport master (
        output FrameData, FrameAddr, FrameValid, FrameWrite, Commit, Lock, ErrorClr,
        input  FrameReady, ReadData, ReadValid, CommitDone, Error, ConfigBits, ConfigBits_N
    );
    modport slave (
        input  FrameData, FrameAddr, FrameValid, FrameWrite, Commit, Lock, ErrorClr,
        output FrameReady, ReadData, ReadValid, CommitDone, Error, ConfigBits, ConfigBits_N
    );
endinterface

// File: rtl/tile_cfg_frame_reg.sv
// tile_cfg_frame_reg: one configuration frame with write enable and masked width
// Ports: i_clk, i_rst_n (async active-low), i_we load strobe, i_d load data, o_q stored frame
module tile_cfg_frame_reg #(
    parameter int W    = 32,
    parameter int USED = 32
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_we,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);
    // bits at or above USED carry no configuration and always read 0
    localparam logic [W-1:0] MASK = {W{1'b1}} >> (W - USED);
    logic [W-1:0] r_q;
    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) r_q <= '0;
        else if (i_we) r_q <= i_d & MASK;
    assign o_q = r_q;
endmodule

// File: rtl/tile_config_mem_ctrl.sv
// tile_config_mem_ctrl: framed configuration memory with optional shadow buffer, readback, commit and error flag
// Ports: CLK, resetn (async active-low), bus (slave side of tile_config_mem_ctrl_if)
module tile_config_mem_ctrl
    import tile_cfg_pkg::*;
#(
    parameter int MaxFramesPerCol = 20,
    parameter int FrameBitsPerRow = 32,
    parameter int NoConfigBits    = 600,
    parameter bit ShadowEnable    = 1'b1
) (
    input logic                   CLK,
    input logic                   resetn,
    tile_config_mem_ctrl_if.slave bus
);
    localparam int W  = FrameBitsPerRow;
    localparam int AW = aw_f(MaxFramesPerCol);
    localparam int NF = (NoConfigBits + W - 1) / W;
    state_t        r_state, w_next;
    logic [AW-1:0] r_addr;
    logic          r_error;
    logic          w_acc, w_mapped, w_wr_ok, w_err_evt;
    logic [W-1:0]  w_src [NF];
    logic [W-1:0]  w_act [NF];
    logic [W-1:0]  w_rdata;

    // gated by resetn so FrameReady stays low while reset is held
    assign bus.FrameReady = resetn && r_state == S_IDLE;
    assign w_acc     = bus.FrameValid && bus.FrameReady;
    assign w_mapped  = frame_mapped(int'(bus.FrameAddr), W, NoConfigBits);
    assign w_wr_ok   = w_acc && bus.FrameWrite && !bus.Lock && w_mapped;
    assign w_err_evt = w_acc && (!w_mapped || (bus.FrameWrite && bus.Lock));

    always_ff @(posedge CLK or negedge resetn)
        if (!resetn) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_error <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_acc) r_addr <= bus.FrameAddr;
            r_error <= w_err_evt || (r_error && !bus.ErrorClr);
        end

    // READ and COMMIT are single-cycle; an accepted write keeps the FSM in IDLE
    always_comb begin
        w_next = S_IDLE;
        if (r_state == S_IDLE)
            w_next = (w_acc && !bus.FrameWrite) ? S_READ :
                     (bus.Commit && !bus.FrameValid) ? S_COMMIT : S_IDLE;
    end

    genvar f;
    generate
        for (f = 0; f < NF; f++) begin : g_frame
            localparam int USED = (NoConfigBits - f * W < W) ? NoConfigBits - f * W : W;
            logic w_wr;
            assign w_wr = w_wr_ok && bus.FrameAddr == AW'(f);
            if (ShadowEnable) begin : g_dbl
                tile_cfg_frame_reg #(.W(W), .USED(USED)) u_shadow (
                    .i_clk(CLK), .i_rst_n(resetn), .i_we(w_wr), .i_d(bus.FrameData), .o_q(w_src[f])
                );
                tile_cfg_frame_reg #(.W(W), .USED(USED)) u_active (
                    .i_clk(CLK), .i_rst_n(resetn), .i_we(r_state == S_COMMIT), .i_d(w_src[f]), .o_q(w_act[f])
                );
            end else begin : g_sgl
                tile_cfg_frame_reg #(.W(W), .USED(USED)) u_active (
                    .i_clk(CLK), .i_rst_n(resetn), .i_we(w_wr), .i_d(bus.FrameData), .o_q(w_act[f])
                );
                assign w_src[f] = w_act[f];
            end
            assign bus.ConfigBits[f*W +: USED] = w_act[f][USED-1:0];
        end
    endgenerate

    // unmapped addresses match no frame and read back as zero
    always_comb begin
        w_rdata = '0;
        for (int i = 0; i < NF; i++)
            if (r_addr == AW'(i)) w_rdata = w_src[i];
    end

    assign bus.ReadValid    = r_state == S_READ;
    assign bus.ReadData     = bus.ReadValid ? w_rdata : '0;
    assign bus.CommitDone   = r_state == S_COMMIT;
    assign bus.Error        = r_error;
    assign bus.ConfigBits_N = ~bus.ConfigBits;
endmodule
